// File: rtl/rv32i_types.sv
// Shared types for the mp4 RV32I core: fetch sequencer state and instruction size.
package rv32i_types;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} fetch_state_t;

  localparam int unsigned INSN_BYTES = 4;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, runs the I-side read handshake, feeds the IR.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt counters.
module fetch_ctrl
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_read,
  output logic [31:0]  imem_address,
  input  logic         imem_resp,
  input  logic [31:0]  imem_rdata,
  output logic         ir_load,
  output logic [31:0]  ir_data,
  output logic [31:0]  ir_pc,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  output fetch_state_t dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  perf_fetch_cnt,
  output logic [31:0]  perf_drop_cnt
`endif
);

  // Handshake: imem_read with a stable imem_address stays high until the cycle
  // imem_resp is seen; that cycle completes the read and imem_rdata is valid.
  // ir_load is a one-cycle valid with no ready: stall is sampled before raising it.

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  ir_pc_q, ir_pc_d;
  logic         read_c, load_c;
  logic [31:0]  data_c;
  logic [31:0]  target;

  assign target = word_align(redirect_pc);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hold_d  = hold_q;
    pend_d  = pend_q;
    ir_pc_d = ir_pc_q;
    read_c  = 1'b0;
    load_c  = 1'b0;
    data_c  = '0;
    case (state_q)
      FETCH: begin
        read_c = 1'b1;
        if (imem_resp) begin
          if (redirect) begin
            pc_d = target;
          end else if (!stall) begin
            load_c  = 1'b1;
            data_c  = imem_rdata;
            ir_pc_d = pc_q;
            pc_d    = pc_q + 32'(INSN_BYTES);
          end else begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end
        end else if (redirect) begin
          pend_d  = target;
          state_d = DROP;
        end
      end
      HOLD: begin
        // Redirect wins over release: the held word belongs to the wrong path.
        if (redirect) begin
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          load_c  = 1'b1;
          data_c  = hold_q;
          ir_pc_d = pc_q;
          pc_d    = pc_q + 32'(INSN_BYTES);
          state_d = FETCH;
        end
      end
      DROP: begin
        read_c = 1'b1;
        if (imem_resp) begin
          pc_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_d = target;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
      pend_q  <= '0;
      ir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  // ir_pc shows the PC of the word being loaded this cycle, else the last one loaded.
  assign imem_read    = rst & read_c;
  assign imem_address = (rst && read_c) ? pc_q : '0;
  assign ir_load      = rst & load_c;
  assign ir_data      = rst ? data_c : '0;
  assign ir_pc        = !rst ? '0 : (load_c ? pc_q : ir_pc_q);
  assign dbg_state    = rst ? state_q : FETCH;

`ifdef FETCH_PERF_EN
  logic word_drop;

  assign word_drop = rst && (((state_q == DROP) && imem_resp) ||
                             ((state_q == FETCH) && imem_resp && redirect) ||
                             ((state_q == HOLD) && redirect));

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (ir_load)   perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (word_drop) perf_drop_cnt  <= perf_drop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a fetch-stream model checked every cycle plus literal anchors.
module tb_fetch_ctrl;
  import rv32i_types::*;

  logic         clk;
  logic         rst;
  logic         imem_read;
  logic [31:0]  imem_address;
  logic         imem_resp;
  logic [31:0]  imem_rdata;
  logic         ir_load;
  logic [31:0]  ir_data;
  logic [31:0]  ir_pc;
  logic         stall;
  logic         redirect;
  logic [31:0]  redirect_pc;
  fetch_state_t dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]  perf_fetch_cnt;
  logic [31:0]  perf_drop_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .ir_load      (ir_load),
    .ir_data      (ir_data),
    .ir_pc        (ir_pc),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .dbg_state    (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_drop_cnt  (perf_drop_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  // Fetch-stream model: a word is either held for decode, or a read is in
  // flight whose result is wanted (or unwanted, with a queued target).
  bit          m_holding;
  logic [31:0] m_held_word;
  bit          m_unwanted;
  logic [31:0] m_queued_target;
  logic [31:0] m_pc;
  logic [31:0] m_last_pc;
  int unsigned m_fetches;
  int unsigned m_drops;

  always @(posedge clk) begin
    if (!rst) begin
      m_holding = 0; m_unwanted = 0; m_held_word = 0; m_queued_target = 0;
      m_pc = 32'h60; m_last_pc = 0; m_fetches = 0; m_drops = 0;
    end else if (m_holding) begin
      if (redirect) begin
        m_holding = 0; m_pc = redirect_pc & ~32'd3; m_drops++;
      end else if (!stall) begin
        m_holding = 0; m_last_pc = m_pc; m_pc = m_pc + 4; m_fetches++;
      end
    end else if (m_unwanted) begin
      if (imem_resp) begin
        m_unwanted = 0; m_drops++;
        m_pc = redirect ? (redirect_pc & ~32'd3) : m_queued_target;
      end else if (redirect) begin
        m_queued_target = redirect_pc & ~32'd3;
      end
    end else if (imem_resp) begin
      if (redirect) begin
        m_pc = redirect_pc & ~32'd3; m_drops++;
      end else if (stall) begin
        m_holding = 1; m_held_word = imem_rdata;
      end else begin
        m_last_pc = m_pc; m_pc = m_pc + 4; m_fetches++;
      end
    end else if (redirect) begin
      m_unwanted = 1; m_queued_target = redirect_pc & ~32'd3;
    end
  end

  // compare process
  always @(negedge clk) begin
    logic        e_read, e_load;
    logic [31:0] e_data;
    if (!rst) begin
      chk("rst_read", {31'd0, imem_read}, 32'd0);
      chk("rst_addr", imem_address, 32'd0);
      chk("rst_load", {31'd0, ir_load}, 32'd0);
      chk("rst_data", ir_data, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'd0);
    end else begin
      if (m_holding) begin
        e_read = 0; e_load = !redirect && !stall; e_data = m_held_word;
      end else begin
        e_read = 1; e_load = imem_resp && !redirect && !stall && !m_unwanted; e_data = imem_rdata;
      end
      if (!e_load) e_data = 0;
      chk("read", {31'd0, imem_read}, {31'd0, e_read});
      if (e_read) chk("addr", imem_address, m_pc);
      chk("load", {31'd0, ir_load}, {31'd0, e_load});
      chk("data", ir_data, e_data);
      chk("ir_pc", ir_pc, e_load ? m_pc : m_last_pc);
      chk("state", {30'd0, dbg_state},
          {30'd0, m_holding ? HOLD : (m_unwanted ? DROP : FETCH)});
`ifdef FETCH_PERF_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetches);
      chk("perf_drop", perf_drop_cnt, m_drops);
`endif
    end
  end

  // driver tasks
  task automatic drive(input logic r, input logic [31:0] d, input logic s,
                       input logic rd, input logic [31:0] rp);
    imem_resp = r; imem_rdata = d; stall = s; redirect = rd; redirect_pc = rp;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic [31:0] d, input logic s,
                      input logic rd, input logic [31:0] rp);
    drive(r, d, s, rd, rp);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    imem_resp = 0; imem_rdata = 0; stall = 0; redirect = 0; redirect_pc = 0;
    drive(0, 0, 0, 0, 0);
    chk("lit_rst_read", {31'd0, imem_read}, 32'd0);
    tick();
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rst = 1'b1;

    // straight-line fetch A,B,C
    drive(0, 0, 0, 0, 0);
    chk("lit_first_read", {31'd0, imem_read}, 32'd1);
    chk("lit_first_addr", imem_address, 32'h60);
    tick();
    drive(1, 32'hA000_000A, 0, 0, 0);
    chk("lit_load_a", {31'd0, ir_load}, 32'd1);
    chk("lit_data_a", ir_data, 32'hA000_000A);
    chk("lit_pc_a", ir_pc, 32'h60);
    tick();
    step(0, 0, 0, 0, 0);
    drive(1, 32'hB000_000B, 0, 0, 0);
    chk("lit_pc_b", ir_pc, 32'h64);
    tick();
    step(0, 0, 0, 0, 0);
    step(1, 32'hC000_000C, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("lit_pc_c_last", ir_pc, 32'h68);
    chk("lit_addr_6c", imem_address, 32'h6C);
    tick();

    // word D returns under stall, held 4 cycles
    drive(1, 32'hD000_000D, 1, 0, 0);
    chk("lit_stall_noload", {31'd0, ir_load}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0, 0);
      chk("lit_hold_noread", {31'd0, imem_read}, 32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("lit_release_d", ir_data, 32'hD000_000D);
    chk("lit_release_pc", ir_pc, 32'h6C);
    tick();

    // redirect two cycles into a 5-cycle read at 0x70
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h200);
    step(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("lit_drop_addr", imem_address, 32'h70);
    tick();
    drive(1, 32'hE000_000E, 0, 0, 0);
    chk("lit_drop_noload", {31'd0, ir_load}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lit_after_drop", imem_address, 32'h200);
`ifdef FETCH_PERF_EN
    chk("lit_perf_drop1", perf_drop_cnt, 32'd1);
`endif
    tick();

    // redirect coincident with resp, unaligned target
    drive(1, 32'hF000_000F, 0, 1, 32'h303);
    chk("lit_coinc_noload", {31'd0, ir_load}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lit_addr_300", imem_address, 32'h300);
    tick();

    // redirect while holding discards the held word
    step(1, 32'h1111_1111, 1, 0, 0);
    drive(0, 0, 1, 1, 32'h400);
    chk("lit_hold_redir_noload", {31'd0, ir_load}, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lit_addr_400", imem_address, 32'h400);
    tick();

    // successive redirects during an unwanted read; latest wins
    step(0, 0, 0, 1, 32'h500);
    step(0, 0, 0, 1, 32'h600);
    step(1, 32'h2222_2222, 0, 1, 32'h700);
    drive(0, 0, 0, 0, 0);
    chk("lit_addr_700", imem_address, 32'h700);
    tick();

    // wrap of the PC past the top of the address space
    step(1, 32'h3333_3333, 0, 1, 32'hFFFF_FFFC);
    drive(1, 32'h4444_4444, 0, 0, 0);
    chk("lit_pc_top", ir_pc, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("lit_addr_wrap", imem_address, 32'h0);
`ifdef FETCH_PERF_EN
    chk("lit_perf_fetch5", perf_fetch_cnt, 32'd5);
    chk("lit_perf_drop5", perf_drop_cnt, 32'd5);
`endif
    tick();

    // reset in the middle of a read, then a late response
    rst = 1'b0;
    step(0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("lit_rerst_addr", imem_address, 32'h60);
    tick();
    drive(1, 32'h5555_5555, 0, 0, 0);
    chk("lit_late_data", ir_data, 32'h5555_5555);
    chk("lit_late_pc", ir_pc, 32'h60);
    tick();
    step(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
